fir_filter_tdm: RTL and testbench

- Parametrised, time-multiplexed FIR filter: one shared multiplier performs one multiply-accumulate (MAC) per clock, so a full output takes NUM_TAPS cycles.
- Coefficients are held in a run-time writable register bank, not hard-wired.
- Valid/ready streaming on input and output; output is rounded, then either wrapped or saturated.
- Sits in the same sample path as the fixed 49-tap filter and replaces it when taps must be changed in system.

---
 rtl/fir_filter_tdm_if.sv | 27 ++
 rtl/fir_filter_tdm.sv | 96 +++++++++
 tb/tb_fir_filter_tdm.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_filter_tdm_if.sv
// fir_filter_tdm_if: sample stream, result stream and coefficient-write port of fir_filter_tdm.
interface fir_filter_tdm_if #(
   parameter int DATA_W   = 16,
   parameter int COEF_W   = 16,
   parameter int NUM_TAPS = 49,
   parameter int AW       = $clog2(NUM_TAPS)
);
   logic                     in_valid;
   logic                     in_ready;
   logic signed [DATA_W-1:0] in_data;
   logic                     out_valid;
   logic                     out_ready;
   logic signed [DATA_W-1:0] out_data;
   logic                     out_sat;
   logic                     coef_we;
   logic [AW-1:0]            coef_addr;
   logic signed [COEF_W-1:0] coef_wdata;
   logic                     busy;
   modport master (
      output in_valid, in_data, out_ready, coef_we, coef_addr, coef_wdata,
      input  in_ready, out_valid, out_data, out_sat, busy
   );
   modport slave (
      input  in_valid, in_data, out_ready, coef_we, coef_addr, coef_wdata,
      output in_ready, out_valid, out_data, out_sat, busy
   );
endinterface

// File: rtl/fir_filter_tdm.sv
// fir_filter_tdm: single-multiplier FIR, one MAC per clock, run-time writable coefficient bank.
// Define FIR_SAT_EN to saturate the rounded output (out_sat flags clamping); otherwise it wraps.
module fir_filter_tdm #(
   parameter int DATA_W    = 16,
   parameter int COEF_W    = 16,
   parameter int NUM_TAPS  = 49,
   parameter int ACC_W     = 40,
   parameter int OUT_SHIFT = 15
) (
   input logic             clk,
   input logic             reset,
   fir_filter_tdm_if.slave bus
);
   localparam int AW = $clog2(NUM_TAPS);
   localparam int PW = DATA_W + COEF_W;
   localparam logic [AW:0] TAPS = (AW+1)'(NUM_TAPS);
   localparam logic [AW-1:0] LAST = AW'(NUM_TAPS - 1);
   localparam logic signed [ACC_W-1:0] HALF = ACC_W'(64'sd1 <<< (OUT_SHIFT - 1));

   typedef enum logic [1:0] {IDLE, MAC, ROUND, OUT} state_t;

   state_t                   state, state_next;
   logic signed [DATA_W-1:0] x [NUM_TAPS];
   logic signed [COEF_W-1:0] coef [NUM_TAPS];
   logic signed [ACC_W-1:0]  acc;
   logic [AW-1:0]            idx;
   logic signed [PW-1:0]     x_ext, c_ext, prod;
   logic signed [DATA_W-1:0] res;
   logic                     res_sat;
   logic                     coef_ok;

   assign bus.in_ready  = state == IDLE;
   assign bus.busy      = state != IDLE;
   assign bus.out_valid = state == OUT;
   assign coef_ok       = {1'b0, bus.coef_addr} < TAPS;

   // Operands are sign-extended to the product width so the low PW bits are exact.
   assign x_ext = {{COEF_W{x[idx][DATA_W-1]}}, x[idx]};
   assign c_ext = {{DATA_W{coef[idx][COEF_W-1]}}, coef[idx]};
   assign prod  = x_ext * c_ext;

`ifdef FIR_SAT_EN
   localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
   logic signed [ACC_W-1:0] rnd;
   assign rnd     = (acc + HALF) >>> OUT_SHIFT;
   assign res_sat = rnd > MAXV || rnd < ~MAXV;
   assign res     = rnd > MAXV ? MAXV[DATA_W-1:0] : rnd < ~MAXV ? ~MAXV[DATA_W-1:0] : rnd[DATA_W-1:0];
`else
   assign res     = DATA_W'((acc + HALF) >>> OUT_SHIFT);
   assign res_sat = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    state_next = bus.in_valid ? MAC : IDLE;
         MAC:     state_next = idx == LAST ? ROUND : MAC;
         ROUND:   state_next = OUT;
         default: state_next = bus.out_ready ? IDLE : OUT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int k = 0; k < NUM_TAPS; k++) begin
            x[k]    <= '0;
            coef[k] <= '0;
         end
         acc          <= '0;
         idx          <= '0;
         bus.out_data <= '0;
         bus.out_sat  <= 1'b0;
      end else begin
         if (state == IDLE && bus.coef_we && coef_ok) coef[bus.coef_addr] <= bus.coef_wdata;
         if (state == IDLE && bus.in_valid) begin
            for (int k = NUM_TAPS - 1; k > 0; k--) x[k] <= x[k-1];
            x[0] <= bus.in_data;
            acc  <= '0;
            idx  <= '0;
         end
         if (state == MAC) begin
            acc <= acc + {{(ACC_W-PW){prod[PW-1]}}, prod};
            idx <= idx + 1'b1;
         end
         if (state == ROUND) begin
            bus.out_data <= res;
            bus.out_sat  <= res_sat;
         end
      end
   end
endmodule

// File: tb/tb_fir_filter_tdm.sv
// tb_fir_filter_tdm: randomized self-checking bench for fir_filter_tdm against a sum-of-products model.
module tb_fir_filter_tdm;
   localparam int DATA_W    = 16;
   localparam int COEF_W    = 16;
   localparam int NUM_TAPS  = 49;
   localparam int ACC_W     = 40;
   localparam int OUT_SHIFT = 15;

   logic   clk = 1'b0;
   logic   reset = 1'b0;
   int     compared = 0;
   int     mismatched = 0;
   longint coef_m [NUM_TAPS];
   longint x_m [NUM_TAPS];

   fir_filter_tdm_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .NUM_TAPS(NUM_TAPS)) bus ();

   fir_filter_tdm #(
      .DATA_W(DATA_W), .COEF_W(COEF_W), .NUM_TAPS(NUM_TAPS), .ACC_W(ACC_W), .OUT_SHIFT(OUT_SHIFT)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      for (int k = 0; k < NUM_TAPS; k++) begin
         coef_m[k] = 0;
         x_m[k]    = 0;
      end
   endtask

   task automatic model_shift(input logic signed [DATA_W-1:0] d);
      for (int k = NUM_TAPS - 1; k > 0; k--) x_m[k] = x_m[k-1];
      x_m[0] = longint'(d);
   endtask

   // y = sum coef[k]*x[n-k], rounded half up, then wrapped or clamped to DATA_W.
   task automatic model(output logic signed [DATA_W-1:0] y, output logic s);
      longint acc, r, maxv, minv;
      acc = 0;
      for (int k = 0; k < NUM_TAPS; k++) acc += coef_m[k] * x_m[k];
      r    = (acc + (longint'(1) << (OUT_SHIFT - 1))) >>> OUT_SHIFT;
      maxv = (longint'(1) << (DATA_W - 1)) - 1;
      minv = -maxv - 1;
`ifdef FIR_SAT_EN
      s = r > maxv || r < minv;
      y = r > maxv ? DATA_W'(maxv) : r < minv ? DATA_W'(minv) : DATA_W'(r);
`else
      s = 1'b0;
      y = DATA_W'(r);
`endif
   endtask

   task automatic write_coef(input int addr, input logic signed [COEF_W-1:0] val);
      bus.coef_we    = 1'b1;
      bus.coef_addr  = 6'(addr);
      bus.coef_wdata = val;
      tick();
      bus.coef_we = 1'b0;
      if (addr < NUM_TAPS) coef_m[addr] = longint'(val);
   endtask

   task automatic push_sample(input logic signed [DATA_W-1:0] d, output logic signed [DATA_W-1:0] y,
                              output logic s, output int lat);
      int n;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      n = 0;
      while (!bus.in_ready && n < 200) begin
         tick();
         n++;
      end
      tick();
      bus.in_valid = 1'b0;
      bus.coef_we  = 1'b0;
      model_shift(d);
      lat = 0;
      while (!bus.out_valid && lat < 200) begin
         tick();
         lat++;
      end
      y = bus.out_data;
      s = bus.out_sat;
      tick();
   endtask

   task automatic test_reset();
      bus.in_valid = 1'b1;
      bus.in_data  = 16'sd123;
      reset = 1'b0;
      repeat (3) tick();
      compared++;
      if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
      compared++;
      if (bus.out_data !== 16'sd0) begin mismatched++; $display("FAIL reset_out_data: got %0d want 0", bus.out_data); end
      compared++;
      if (bus.busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      compared++;
      if (bus.out_sat !== 1'b0) begin mismatched++; $display("FAIL reset_out_sat: got %b want 0", bus.out_sat); end
      reset = 1'b1;
      bus.in_valid = 1'b0;
      tick();
      compared++;
      if (bus.in_ready !== 1'b1) begin mismatched++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
      compared++;
      if (bus.busy !== 1'b0) begin mismatched++; $display("FAIL reset_no_accept: busy got %b want 0", bus.busy); end
   endtask

   task automatic test_impulse();
      logic signed [DATA_W-1:0] y, exp;
      logic s;
      int lat;
      for (int k = 0; k < 8; k++) write_coef(k, 16'(1024 * (k + 1)));
      for (int i = 0; i < 10; i++) begin
         push_sample(i == 0 ? 16'sd32 : 16'sd0, y, s, lat);
         exp = i < 8 ? 16'(i + 1) : 16'sd0;
         compared++;
         if (y !== exp) begin mismatched++; $display("FAIL impulse_data[%0d]: got %0d want %0d", i, y, exp); end
         compared++;
         if (lat != NUM_TAPS + 1) begin mismatched++; $display("FAIL impulse_latency[%0d]: got %0d want %0d", i, lat, NUM_TAPS + 1); end
      end
   endtask

   task automatic test_backpressure();
      logic signed [DATA_W-1:0] held, exp;
      logic es;
      int n;
      bus.out_ready = 1'b0;
      bus.in_data   = 16'($urandom);
      bus.in_valid  = 1'b1;
      tick();
      model_shift(bus.in_data);
      bus.in_valid = 1'b0;
      n = 0;
      while (!bus.out_valid && n < 200) begin
         tick();
         n++;
      end
      model(exp, es);
      held = bus.out_data;
      compared++;
      if (held !== exp) begin mismatched++; $display("FAIL bp_data: got %0d want %0d", held, exp); end
      for (int i = 0; i < 10; i++) begin
         bus.in_valid = i % 3 == 0;
         bus.in_data  = 16'sh1234;
         tick();
         compared++;
         if (bus.out_valid !== 1'b1) begin mismatched++; $display("FAIL bp_valid_held[%0d]: got %b want 1", i, bus.out_valid); end
         compared++;
         if (bus.out_data !== held) begin mismatched++; $display("FAIL bp_data_held[%0d]: got %0d want %0d", i, bus.out_data, held); end
         compared++;
         if (bus.in_ready !== 1'b0) begin mismatched++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, bus.in_ready); end
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      compared++;
      if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL bp_release_valid: got %b want 0", bus.out_valid); end
      compared++;
      if (bus.busy !== 1'b0) begin mismatched++; $display("FAIL bp_release_idle: busy got %b want 0", bus.busy); end
   endtask

   task automatic test_overflow();
      logic signed [DATA_W-1:0] y, exp;
      logic s, es;
      int lat;
      for (int k = 0; k < NUM_TAPS; k++) write_coef(k, 16'sh7FFF);
      for (int i = 0; i < NUM_TAPS; i++) begin
         push_sample(16'sh7FFF, y, s, lat);
         model(exp, es);
         compared++;
         if (y !== exp || s !== es) begin
            mismatched++;
            $display("FAIL overflow_model[%0d]: got %0d/%b want %0d/%b", i, y, s, exp, es);
         end
      end
`ifdef FIR_SAT_EN
      exp = 16'sh7FFF;
      es  = 1'b1;
`else
      exp = 16'sh7F9E;
      es  = 1'b0;
`endif
      compared++;
      if (y !== exp || s !== es) begin mismatched++; $display("FAIL overflow_final: got %0d/%b want %0d/%b", y, s, exp, es); end
   endtask

   task automatic test_illegal_writes();
      logic signed [DATA_W-1:0] y, exp;
      logic s, es;
      int lat, n;
      write_coef(0, 16'sd4096);
      for (int k = 1; k < NUM_TAPS; k++) write_coef(k, 16'sd0);
      bus.in_data  = 16'sd32;
      bus.in_valid = 1'b1;
      tick();
      model_shift(16'sd32);
      bus.in_valid   = 1'b0;
      bus.coef_we    = 1'b1;
      bus.coef_addr  = 6'd0;
      bus.coef_wdata = 16'sd8192;
      repeat (5) tick();
      bus.coef_we = 1'b0;
      n = 0;
      while (!bus.out_valid && n < 200) begin
         tick();
         n++;
      end
      compared++;
      if (bus.out_data !== 16'sd4) begin mismatched++; $display("FAIL busy_write_first: got %0d want 4", bus.out_data); end
      tick();
      push_sample(16'sd32, y, s, lat);
      compared++;
      if (y !== 16'sd4) begin mismatched++; $display("FAIL busy_write_dropped: got %0d want 4", y); end
      write_coef(NUM_TAPS, 16'sh7FFF);
      write_coef(63, -16'sd1);
      for (int i = 0; i < 20; i++) begin
         push_sample(16'($urandom), y, s, lat);
         model(exp, es);
         compared++;
         if (y !== exp || s !== es) begin
            mismatched++;
            $display("FAIL bad_addr_write[%0d]: got %0d/%b want %0d/%b", i, y, s, exp, es);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic signed [DATA_W-1:0] y, exp;
      logic s, es;
      int lat, a, v;
      for (int k = 0; k < NUM_TAPS; k++) write_coef(k, 16'($urandom_range(0, 4095) - 2048));
      for (int i = 0; i < 30; i++) begin
         if ($urandom_range(0, 2) == 0) begin
            a = $urandom_range(0, NUM_TAPS - 1);
            v = $urandom_range(0, 65535) - 32768;
            bus.coef_we    = 1'b1;
            bus.coef_addr  = 6'(a);
            bus.coef_wdata = 16'(v);
            coef_m[a] = longint'(v);
         end
         push_sample(16'($urandom), y, s, lat);
         model(exp, es);
         compared++;
         if (y !== exp || s !== es) begin
            mismatched++;
            $display("FAIL random_out[%0d]: got %0d/%b want %0d/%b", i, y, s, exp, es);
         end
         compared++;
         if (lat != NUM_TAPS + 1) begin mismatched++; $display("FAIL random_latency[%0d]: got %0d want %0d", i, lat, NUM_TAPS + 1); end
      end
   endtask

   task automatic test_reset_mid_mac();
      logic signed [DATA_W-1:0] y;
      logic s;
      int lat;
      bus.in_data  = 16'($urandom);
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      repeat (20) tick();
      compared++;
      if (bus.busy !== 1'b1) begin mismatched++; $display("FAIL mid_mac_busy: got %b want 1", bus.busy); end
      reset = 1'b0;
      tick();
      reset = 1'b1;
      model_clear();
      compared++;
      if (bus.busy !== 1'b0) begin mismatched++; $display("FAIL mid_mac_idle: busy got %b want 0", bus.busy); end
      compared++;
      if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL mid_mac_valid: got %b want 0", bus.out_valid); end
      compared++;
      if (bus.in_ready !== 1'b1) begin mismatched++; $display("FAIL mid_mac_in_ready: got %b want 1", bus.in_ready); end
      push_sample(16'sd32, y, s, lat);
      compared++;
      if (y !== 16'sd0) begin mismatched++; $display("FAIL mid_mac_impulse: got %0d want 0", y); end
      compared++;
      if (lat != NUM_TAPS + 1) begin mismatched++; $display("FAIL mid_mac_latency: got %0d want %0d", lat, NUM_TAPS + 1); end
      push_sample(16'sh7FFF, y, s, lat);
      compared++;
      if (y !== 16'sd0) begin mismatched++; $display("FAIL mid_mac_coef_clear: got %0d want 0", y); end
   endtask

   initial begin
      bus.in_valid   = 1'b0;
      bus.in_data    = '0;
      bus.out_ready  = 1'b1;
      bus.coef_we    = 1'b0;
      bus.coef_addr  = '0;
      bus.coef_wdata = '0;
      model_clear();
      test_reset();
      test_impulse();
      test_backpressure();
      test_overflow();
      test_illegal_writes();
      test_back_to_back();
      test_reset_mid_mac();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
